// File: rtl/timer_setter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : timer_setter                                                  |
// | Purpose  : Front-panel time-entry controller. Synchronizes the raw       |
// |            push-buttons, edits a four-digit BCD MM:SS preset one digit   |
// |            at a time with wrap-around and auto-repeat, and issues the    |
// |            load / start strobes for the countdown chain.                 |
// | Ports    : clk        - system clock, rising edge                        |
// |            reset      - asynchronous, active-low reset                   |
// |            tick       - one-clk enable pulse (~10 Hz) for auto-repeat    |
// |            btn_up/btn_down/btn_next/btn_start - raw active-high buttons  |
// |            running    - countdown chain is counting                      |
// |            sec_ones/sec_tens/min_ones/min_tens - BCD preset digits       |
// |            digit_sel  - digit under edit (0 = sec_ones .. 3 = min_tens)  |
// |            editing    - high while in EDIT                               |
// |            load       - one-clk strobe, chain samples the digits         |
// |            start      - one-clk strobe, arms the countdown               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module timer_setter #(
  parameter int REPEAT_DELAY = 5,
  parameter int REPEAT_RATE  = 2,
  parameter int CTR_WIDTH    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_next,
  input  logic       btn_start,
  input  logic       running,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [1:0] digit_sel,
  output logic       editing,
  output logic       load,
  output logic       start
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EDIT = 1'b1
  } state_t;

  // Counter value on the tick that fires a step, and the value it is reloaded
  // with so the following step lands exactly REPEAT_RATE ticks later.
  localparam logic [CTR_WIDTH-1:0] c_DELAY_M1 = CTR_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CTR_WIDTH-1:0] c_RELOAD   = CTR_WIDTH'(REPEAT_DELAY - REPEAT_RATE);

  // Button vectors: bit 0 up, bit 1 down, bit 2 next, bit 3 start.
  logic [3:0]           r_sync1;
  logic [3:0]           r_sync2;
  logic [3:0]           r_prev;
  logic                 r_running_d;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0][3:0]      r_dig;
  logic [3:0][3:0]      w_dig_nxt;
  logic [1:0]           r_sel;
  logic [1:0]           w_sel_nxt;
  logic [CTR_WIDTH-1:0] r_ctr;
  logic [CTR_WIDTH-1:0] w_ctr_nxt;
  logic                 r_load;
  logic                 w_load_nxt;
  logic                 r_start;
  logic                 w_start_nxt;

  logic [3:0]           w_edge;
  logic                 w_run_rise;
  logic                 w_preset_zero;
  logic [3:0]           w_lim;
  logic [3:0]           w_cur;
  logic                 w_step;
  logic                 w_step_up;

  assign w_edge        = r_sync2 & ~r_prev;
  assign w_run_rise    = running & ~r_running_d;
  assign w_preset_zero = (r_dig == '0);
  assign w_lim         = (r_sel == 2'd1) ? 4'd5 : 4'd9;
  assign w_cur         = r_dig[r_sel];
  // Direction is only meaningful when exactly one of up/down is held.
  assign w_step_up     = r_sync2[0];

  // Input conditioning: 2-FF synchronizer plus a delayed copy for edge detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_prev      <= '0;
      r_running_d <= 1'b0;
    end else begin
      r_sync1     <= {btn_start, btn_next, btn_down, btn_up};
      r_sync2     <= r_sync1;
      r_prev      <= r_sync2;
      r_running_d <= running;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_dig   <= '0;
      r_sel   <= 2'd0;
      r_ctr   <= '0;
      r_load  <= 1'b0;
      r_start <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dig   <= w_dig_nxt;
      r_sel   <= w_sel_nxt;
      r_ctr   <= w_ctr_nxt;
      r_load  <= w_load_nxt;
      r_start <= w_start_nxt;
    end
  end

  // Next-state, strobes and digit editing. Priority inside EDIT:
  // running abort > start > next > up/down.
  always_comb begin
    w_state_nxt = r_state;
    w_dig_nxt   = r_dig;
    w_sel_nxt   = r_sel;
    w_ctr_nxt   = '0;
    w_load_nxt  = 1'b0;
    w_start_nxt = 1'b0;
    w_step      = 1'b0;

    case (r_state)
      S_IDLE: begin
        // A start edge consumes the cycle even when it is gated off.
        if (w_edge[3]) begin
          if (!running && !w_preset_zero) begin
            w_start_nxt = 1'b1;
          end
        end else if (w_edge[2] && !running) begin
          w_state_nxt = S_EDIT;
          w_sel_nxt   = 2'd3;
        end
      end

      S_EDIT: begin
        if (w_run_rise) begin
          w_state_nxt = S_IDLE;
        end else if (w_edge[3]) begin
          w_state_nxt = S_IDLE;
          w_load_nxt  = 1'b1;
        end else if (w_edge[2]) begin
          if (r_sel == 2'd0) begin
            w_state_nxt = S_IDLE;
            w_load_nxt  = 1'b1;
          end else begin
            w_sel_nxt = r_sel - 2'd1;
          end
        end else if (r_sync2[0] ^ r_sync2[1]) begin
          if (w_edge[0] | w_edge[1]) begin
            w_step = 1'b1;
          end else if (tick) begin
            if (r_ctr == c_DELAY_M1) begin
              w_step    = 1'b1;
              w_ctr_nxt = c_RELOAD;
            end else begin
              w_ctr_nxt = r_ctr + 1'b1;
            end
          end else begin
            w_ctr_nxt = r_ctr;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_step) begin
      if (w_step_up) begin
        w_dig_nxt[r_sel] = (w_cur == w_lim) ? 4'd0 : w_cur + 4'd1;
      end else begin
        w_dig_nxt[r_sel] = (w_cur == 4'd0) ? w_lim : w_cur - 4'd1;
      end
    end
  end

  assign sec_ones  = r_dig[0];
  assign sec_tens  = r_dig[1];
  assign min_ones  = r_dig[2];
  assign min_tens  = r_dig[3];
  assign digit_sel = r_sel;
  assign editing   = (r_state == S_EDIT);
  assign load      = r_load;
  assign start     = r_start;

endmodule
`default_nettype wire

// File: tb/tb_timer_setter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_timer_setter                                               |
// | Purpose  : Self-checking bench for timer_setter: directed entry-path     |
// |            scenarios with literal expectations, then randomized buttons, |
// |            ticks, running and resets against a behavioural model.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_timer_setter;

  localparam int DELAY = 5;
  localparam int RATE  = 2;

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic       tick    = 1'b0;
  logic       running = 1'b0;
  logic [3:0] btn     = '0;   // bit 0 up, 1 down, 2 next, 3 start
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic [1:0] digit_sel;
  logic       editing, load, start;

  int n_checks  = 0;
  int n_fail    = 0;
  int load_cnt  = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  timer_setter #(
    .REPEAT_DELAY(DELAY),
    .REPEAT_RATE (RATE),
    .CTR_WIDTH   (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .btn_up   (btn[0]),
    .btn_down (btn[1]),
    .btn_next (btn[2]),
    .btn_start(btn[3]),
    .running  (running),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
    .min_tens (min_tens),
    .digit_sel(digit_sel),
    .editing  (editing),
    .load     (load),
    .start    (start)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model sees each button two edges late (synchronizer) and detects a
  // press as "high now, low one sample earlier".
  int         md[4];
  int         m_sel;
  bit         m_edit, m_load, m_start, m_run_prev;
  int         m_held;           // ticks counted while one of up/down is held
  logic [3:0] h1, h2, h3;       // raw samples 1, 2 and 3 edges ago

  task automatic model_reset();
    for (int i = 0; i < 4; i++) md[i] = 0;
    m_sel = 0; m_edit = 0; m_load = 0; m_start = 0; m_run_prev = 0;
    m_held = 0; h1 = '0; h2 = '0; h3 = '0;
  endtask

  task automatic bump(input bit up);
    int lim;
    lim = (m_sel == 1) ? 5 : 9;
    if (up) md[m_sel] = (md[m_sel] == lim) ? 0 : md[m_sel] + 1;
    else    md[m_sel] = (md[m_sel] == 0) ? lim : md[m_sel] - 1;
  endtask

  task automatic model_step();
    logic [3:0] lvl, e;
    bit         rr;
    lvl = h2;
    e   = h2 & ~h3;
    rr  = running && !m_run_prev;
    m_load = 0; m_start = 0;
    if (!m_edit) begin
      m_held = 0;
      if (e[3]) begin
        if (!running && (md[0] + md[1] + md[2] + md[3]) != 0) m_start = 1;
      end else if (e[2] && !running) begin
        m_edit = 1; m_sel = 3;
      end
    end else if (rr) begin
      m_edit = 0; m_held = 0;
    end else if (e[3]) begin
      m_edit = 0; m_load = 1; m_held = 0;
    end else if (e[2]) begin
      m_held = 0;
      if (m_sel == 0) begin m_edit = 0; m_load = 1; end
      else m_sel--;
    end else if (lvl[0] != lvl[1]) begin
      if (e[0] | e[1]) begin
        m_held = 0;
        bump(lvl[0]);
      end else if (tick) begin
        m_held++;
        if (m_held == DELAY || (m_held > DELAY && (m_held - DELAY) % RATE == 0))
          bump(lvl[0]);
      end
    end else begin
      m_held = 0;
    end
    m_run_prev = running;
    h3 = h2; h2 = h1; h1 = btn;
  endtask

  // Single compare process: advance the model on each edge, check 1 ns later.
  always @(posedge clk) begin
    if (!reset) model_reset();
    else        model_step();
    #1;
    check("sec_ones",  sec_ones,  md[0]);
    check("sec_tens",  sec_tens,  md[1]);
    check("min_ones",  min_ones,  md[2]);
    check("min_tens",  min_tens,  md[3]);
    check("digit_sel", digit_sel, m_sel);
    check("editing",   editing,   m_edit);
    check("load",      load,      m_load);
    check("start",     start,     m_start);
    if (load === 1'b1)  load_cnt++;
    if (start === 1'b1) start_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] m, input int times);
    for (int i = 0; i < times; i++) begin
      btn = btn | m;
      cyc(1);
      btn = btn & ~m;
      cyc(3);
    end
  endtask

  task automatic hold_ticks(input logic [3:0] m, input int nticks);
    btn = btn | m;
    cyc(3);
    for (int i = 0; i < nticks; i++) begin
      tick = 1'b1; cyc(1);
      tick = 1'b0; cyc(2);
    end
    btn = btn & ~m;
    cyc(3);
  endtask

  initial begin
    #2 reset = 1'b0;
    cyc(3);
    reset = 1'b1;

    // Idle after reset: nothing moves, start with preset 00:00 is ignored.
    cyc(100);
    check("idle_digits_zero", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
    press(4'b1000, 1);
    check("start_blocked_zero_preset", start_cnt, 0);

    // Entry path.
    press(4'b0100, 1);
    check("enter_edit", editing, 1);
    check("enter_sel3", digit_sel, 3);
    press(4'b0001, 3);
    check("min_tens_3", min_tens, 3);
    press(4'b0100, 1); press(4'b0001, 5);
    check("min_ones_5", min_ones, 5);
    press(4'b0100, 1); press(4'b0010, 1);
    check("sec_tens_wrap_5", sec_tens, 5);
    press(4'b0100, 1); press(4'b0001, 10);
    check("sec_ones_wrap_0", sec_ones, 0);
    check("no_load_yet", load_cnt, 0);
    press(4'b0100, 1);
    check("final_next_idle", editing, 0);
    check("final_next_load", load_cnt, 1);
    check("entry_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h3550);

    // Auto-repeat on sec_ones: 1 edge step + ticks 5, 7, 9, 11.
    press(4'b0100, 4);
    check("sel0_again", digit_sel, 0);
    hold_ticks(4'b0001, 11);
    check("autorepeat_5_steps", sec_ones, 5);

    // Up and down together: no movement.
    hold_ticks(4'b0011, 10);
    check("updown_no_step", sec_ones, 5);

    // Start and next together in EDIT: load, back to IDLE, no start.
    press(4'b1100, 1);
    check("start_next_load", load_cnt, 2);
    check("start_next_idle", editing, 0);
    check("start_next_nostart", start_cnt, 0);

    // Rework preset to 01:00 and start it.
    press(4'b0100, 1); press(4'b0010, 3);
    press(4'b0100, 1); press(4'b0010, 4);
    press(4'b0100, 1); press(4'b0001, 1);
    press(4'b0100, 1); press(4'b0001, 5);
    press(4'b0100, 1);
    check("preset_0100", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0100);
    check("preset_load", load_cnt, 3);
    press(4'b1000, 1);
    check("start_pulse", start_cnt, 1);

    // While running, start and next are ignored.
    running = 1'b1; cyc(2);
    press(4'b1000, 1);
    press(4'b0100, 1);
    check("running_no_start", start_cnt, 1);
    check("running_no_edit", editing, 0);
    running = 1'b0; cyc(2);

    // Running rising during EDIT aborts without load, edits kept.
    press(4'b0100, 1); press(4'b0001, 1);
    running = 1'b1; cyc(3);
    check("abort_idle", editing, 0);
    check("abort_no_load", load_cnt, 3);
    check("abort_keeps_digit", min_tens, 1);
    running = 1'b0; cyc(2);

    // Asynchronous reset mid-edit at digit_sel = 2.
    press(4'b0100, 2);
    check("pre_reset_sel2", digit_sel, 2);
    #2 reset = 1'b0;
    #1;
    check("async_rst_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
    check("async_rst_state", {digit_sel, editing, load, start}, 5'd0);
    @(negedge clk); reset = 1'b1;
    cyc(3);
    check("reset_no_load", load_cnt, 3);

    // Randomized phase.
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 599) == 0) reset = 1'b0;
      if ($urandom_range(0, 23) == 0) btn[0] = ~btn[0];
      if ($urandom_range(0, 23) == 0) btn[1] = ~btn[1];
      if ($urandom_range(0, 9)  == 0) btn[2] = ~btn[2];
      if ($urandom_range(0, 11) == 0) btn[3] = ~btn[3];
      if ($urandom_range(0, 79) == 0) running = ~running;
      tick = ($urandom_range(0, 2) == 0);
    end
    reset = 1'b1; btn = '0; tick = 1'b0;
    cyc(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer_setter.md
# timer_setter

Front-panel time-entry controller for the egg timer. Turns raw push-buttons into a four-digit BCD preset (MM:SS, 00:00–99:59), with per-digit editing, wrap-around and auto-repeat. Produces the `load` strobe that copies the preset into the `digit_counter` countdown chain's `start_count` inputs, and the `start` strobe that arms it. It is the writer side of the preset interface that the countdown chain reads.

## Interface
Parameters:
- `REPEAT_DELAY`, 5: `tick` pulses a button must be held before auto-repeat begins.
- `REPEAT_RATE`, 2: `tick` pulses between auto-repeat steps.
- `CTR_WIDTH`, 4: width of the internal repeat counter; must hold `REPEAT_DELAY`.

Ports:
- `clk` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `tick` in 1: one-`clk` enable pulse from a `clock_divider`, nominally 10 Hz.
- `btn_up`, `btn_down`, `btn_next`, `btn_start` in 1 each: raw, asynchronous, active-high buttons.
- `running` in 1: high while the countdown chain is counting.
- `sec_ones`, `sec_tens`, `min_ones`, `min_tens` out 4 each: BCD preset digits.
- `digit_sel` out 2: digit under edit; 0 = `sec_ones`, 1 = `sec_tens`, 2 = `min_ones`, 3 = `min_tens`.
- `editing` out 1: high in EDIT.
- `load` out 1: one-`clk` pulse; the chain samples the digits on it.
- `start` out 1: one-`clk` pulse; arms the countdown.

## Operation
- Each button goes through a 2-FF synchronizer, then rising-edge detection on the synchronized value.
- FSM states: IDLE and EDIT. Reset state is IDLE.
- IDLE:
  - `next` edge with `running`=0: enter EDIT, `digit_sel`=3.
  - `start` edge with `running`=0 and preset ≠ 00:00: pulse `start`.
  - All other button events are ignored.
- EDIT:
  - `next` edge: `digit_sel` decrements. At `digit_sel`=0, `next` returns to IDLE and pulses `load`.
  - `start` edge: pulse `load` and return to IDLE. `start` is not pulsed; a second press is required to start.
  - `running` rising while in EDIT: abort to IDLE. No `load` pulse; digits keep their edited values.
- Up/down act on the selected digit only, and only in EDIT:
  - Limits: `sec_tens` is 0..5; every other digit is 0..9.
  - Up at the maximum wraps to 0. Down at 0 wraps to the maximum.
  - No carry or borrow into neighbouring digits.
  - Up and down both asserted (synchronized) in the same cycle: no step, and the repeat counter is cleared.
- Auto-repeat:
  - While exactly one of up/down is held in EDIT, the repeat counter counts `tick` pulses.
  - After `REPEAT_DELAY` ticks, one step occurs; after that, one step every `REPEAT_RATE` ticks.
  - Release, a `digit_sel` change, or leaving EDIT clears the counter.
- `next` and `start` edges in the same cycle: `start` wins.
- Priority within one cycle: reset > `running` abort > `start` > `next` > up/down.

## Timing
- Reset values: all digits 0, `digit_sel`=0, `editing`=0, `load`=0, `start`=0, synchronizers 0, repeat counter 0.
- Reset mid-edit: immediate return to the reset state. No `load` is emitted.
- Latency: a raw button first sampled high at rising edge N produces its effect (digit step, state change, strobe) at edge N+2, visible after N+2.
- `load` and `start` are exactly one `clk` wide and registered, not combinational.
- The digit outputs are stable whenever `load` is high. The cycle carrying `load` has no digit update.
- `editing` changes on the same edge as the state transition.
- A held button produces exactly one edge-triggered step plus the auto-repeat steps. Releasing and re-pressing gives a new edge.

## Test plan
- Reset then idle: release `reset` with no buttons pressed. All outputs stay 0 for 100 cycles; a `start` press gives no `start` pulse (preset is 00:00).
- Entry path:
  - Press `next`. Then `up` ×3 on `min_tens` → 3.
  - `next`, `up` ×5 → `min_ones`=5.
  - `next`, `down` ×1 → `sec_tens`=5 (wrap from 0).
  - `next`, `up` ×10 → `sec_ones`=0 (wrap).
  - Final `next`: IDLE, one `load` pulse, digits read 3,5,5,0.
- Auto-repeat: with `REPEAT_DELAY`=5 and `REPEAT_RATE`=2, hold `up` on `sec_ones` for 11 ticks. Count is 1 (edge) + 1 (tick 5) + 3 (ticks 7, 9, 11) = 5 steps.
- Simultaneous up+down held for 10 ticks: no digit change. `start` and `next` pressed in the same cycle in EDIT: one `load`, IDLE, no `start` pulse.
- Start gating:
  - Preset 01:00, IDLE, `running`=0: press `start` → one `start` pulse.
  - With `running`=1: `start` and `next` are ignored.
  - `running` rising during EDIT: abort to IDLE with no `load`.
- Async reset mid-edit at `digit_sel`=2: outputs go to reset values immediately, before the next clock edge, with no `load` glitch.
